// File: rtl/arcade_input_mapper_if.sv
// Input/output bundle between hps_io-side sources and the arcade_input_mapper.
// The master drives keyboard/joystick/config and reads the per-player control outputs.
interface arcade_input_mapper_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BUTTONS = 2
);
    logic [10:0]                        ps2_key;
    logic [16*NUM_PLAYERS-1:0]          joystick;
    logic [1:0]                         rotate;
    logic [NUM_BUTTONS-1:0]             autofire_mask;
    logic [4*NUM_PLAYERS-1:0]           dir;
    logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn;
    logic [NUM_PLAYERS-1:0]             start;
    logic [NUM_PLAYERS-1:0]             coin;

    modport master (
        output ps2_key, joystick, rotate, autofire_mask,
        input  dir, btn, start, coin
    );

    modport slave (
        input  ps2_key, joystick, rotate, autofire_mask,
        output dir, btn, start, coin
    );
endinterface

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 key events and MiSTer joystick words into registered per-player dir/btn/start/coin.
// Latency: joystick->out 1 cycle, key event->out 2 cycles; no backpressure. Autofire: ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_mapper #(
    parameter int          NUM_PLAYERS     = 2,
    parameter int          NUM_BUTTONS     = 2,
    parameter logic [15:0] COIN_PULSE      = 16'd36000,
    parameter logic [19:0] AUTOFIRE_PERIOD = 20'd600000
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    arcade_input_mapper_if.slave  bus
);

    // {hit, player, joystick-format bit index}
    function automatic logic [6:0] f_decode(input logic [8:0] code);
        case (code)
            9'h175: f_decode = {1'b1, 2'd0, 4'd3};
            9'h172: f_decode = {1'b1, 2'd0, 4'd2};
            9'h16B: f_decode = {1'b1, 2'd0, 4'd1};
            9'h174: f_decode = {1'b1, 2'd0, 4'd0};
            9'h014: f_decode = {1'b1, 2'd0, 4'd4};
            9'h011: f_decode = {1'b1, 2'd0, 4'd5};
            9'h029: f_decode = {1'b1, 2'd0, 4'd6};
            9'h012: f_decode = {1'b1, 2'd0, 4'd7};
            9'h02D: f_decode = {1'b1, 2'd1, 4'd3};
            9'h02B: f_decode = {1'b1, 2'd1, 4'd2};
            9'h023: f_decode = {1'b1, 2'd1, 4'd1};
            9'h034: f_decode = {1'b1, 2'd1, 4'd0};
            9'h01C: f_decode = {1'b1, 2'd1, 4'd4};
            9'h01B: f_decode = {1'b1, 2'd1, 4'd5};
            9'h015: f_decode = {1'b1, 2'd1, 4'd6};
            9'h01D: f_decode = {1'b1, 2'd1, 4'd7};
            9'h016: f_decode = {1'b1, 2'd0, 4'd8};
            9'h01E: f_decode = {1'b1, 2'd1, 4'd8};
            9'h026: f_decode = {1'b1, 2'd2, 4'd8};
            9'h025: f_decode = {1'b1, 2'd3, 4'd8};
            9'h02E: f_decode = {1'b1, 2'd0, 4'd9};
            9'h036: f_decode = {1'b1, 2'd1, 4'd9};
            9'h03D: f_decode = {1'b1, 2'd2, 4'd9};
            9'h03E: f_decode = {1'b1, 2'd3, 4'd9};
            default: f_decode = 7'd0;
        endcase
    endfunction

    logic                         r_primed;
    logic                         r_old_toggle;
    logic [NUM_PLAYERS-1:0][9:0]  r_key;
    logic [6:0]                   w_dec;

    assign w_dec = f_decode(bus.ps2_key[8:0]);

    // Key latches use the joystick bit layout so the merge is a plain OR.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_primed     <= 1'b0;
            r_old_toggle <= 1'b0;
            r_key        <= '0;
        end else if (!r_primed) begin
            r_primed     <= 1'b1;
            r_old_toggle <= bus.ps2_key[10];
        end else if (bus.ps2_key[10] != r_old_toggle) begin
            r_old_toggle <= bus.ps2_key[10];
            if (w_dec[6]) begin
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    if (w_dec[5:4] == p[1:0])
                        r_key[p][w_dec[3:0]] <= bus.ps2_key[9];
                end
            end
        end
    end

    logic w_af_phase;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [19:0] r_af_cnt;
    logic        r_af_phase;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_af_cnt   <= 20'd0;
            r_af_phase <= 1'b1;
        end else if (r_af_cnt >= AUTOFIRE_PERIOD - 20'd1) begin
            r_af_cnt   <= 20'd0;
            r_af_phase <= ~r_af_phase;
        end else begin
            r_af_cnt   <= r_af_cnt + 20'd1;
        end
    end
    assign w_af_phase = r_af_phase;
`else
    logic w_unused_af;
    assign w_af_phase  = 1'b1;
    assign w_unused_af = ^bus.autofire_mask;
`endif

    for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_pl
        logic [9:0]             w_raw;
        logic [5:0]             w_unused_hi;
        logic                   w_u, w_d, w_l, w_r;
        logic [3:0]             w_dir;
        logic [NUM_BUTTONS-1:0] w_btn;
        logic [15:0]            w_cnt_nxt;
        logic [15:0]            r_cnt;
        logic                   r_coin_prev;
        logic [3:0]             r_dir;
        logic [NUM_BUTTONS-1:0] r_btn;
        logic                   r_start;
        logic                   r_coin;

        assign w_raw       = r_key[gp] | bus.joystick[16*gp +: 10];
        assign w_unused_hi = bus.joystick[16*gp+10 +: 6];

        if (NUM_BUTTONS < 4) begin : g_unused_btn
            logic [3-NUM_BUTTONS:0] w_unused_btn;
            assign w_unused_btn = w_raw[7:4+NUM_BUTTONS];
        end

        always_comb begin
            w_u = w_raw[3];
            w_d = w_raw[2];
            w_l = w_raw[1];
            w_r = w_raw[0];
            case (bus.rotate)
                2'd1: begin w_u = w_raw[1]; w_d = w_raw[0]; w_l = w_raw[2]; w_r = w_raw[3]; end
                2'd2: begin w_u = w_raw[2]; w_d = w_raw[3]; w_l = w_raw[0]; w_r = w_raw[1]; end
                2'd3: begin w_u = w_raw[0]; w_d = w_raw[1]; w_l = w_raw[3]; w_r = w_raw[2]; end
                default: ;
            endcase
        end

        assign w_dir = {w_u & ~w_d, w_d & ~w_u, w_l & ~w_r, w_r & ~w_l};
        assign w_btn = w_raw[4 +: NUM_BUTTONS] & (~bus.autofire_mask | {NUM_BUTTONS{w_af_phase}});

        // Edges arriving while the pulse runs are dropped, not queued.
        always_comb begin
            w_cnt_nxt = r_cnt;
            if (r_cnt != 16'd0)
                w_cnt_nxt = r_cnt - 16'd1;
            else if (w_raw[9] && !r_coin_prev)
                w_cnt_nxt = COIN_PULSE;
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt       <= 16'd0;
                r_coin_prev <= 1'b0;
                r_dir       <= 4'd0;
                r_btn       <= '0;
                r_start     <= 1'b0;
                r_coin      <= 1'b0;
            end else begin
                r_cnt       <= w_cnt_nxt;
                r_coin_prev <= w_raw[9];
                r_dir       <= w_dir;
                r_btn       <= w_btn;
                r_start     <= w_raw[8];
                r_coin      <= (w_cnt_nxt != 16'd0);
            end
        end

        assign bus.dir[4*gp +: 4]                     = r_dir;
        assign bus.btn[NUM_BUTTONS*gp +: NUM_BUTTONS] = r_btn;
        assign bus.start[gp]                          = r_start;
        assign bus.coin[gp]                           = r_coin;
    end

endmodule
